uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

Serial command receiver for the scoreboard. It receives 8-bit UART frames on `rxd` (16x oversampled, LSB first) from the host PC and decodes ASCII command bytes into single-cycle control pulses and level outputs for scoring, team select and clock run. It is the inbound counterpart of the scoreboard's serial transmitter and sits beside it at the top level, on the system clock domain.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate.
- `DIV`, default `CLK_FREQ/(BAUD*16)` (integer, truncating; 325 at defaults): clocks per oversample tick.

Ports:
- `clk`, input, 1: system clock; everything is on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `rxd`, input, 1: serial line, idle high, asynchronous to `clk`.
- `rx_data`, output, 8: last good byte; holds until the next good byte.
- `rx_valid`, output, 1: one-cycle strobe when `rx_data` updates.
- `frame_err`, output, 1: one-cycle strobe when a frame has a bad stop bit.
- `parity_err`, output, 1: one-cycle strobe on a parity mismatch; tied to 0 unless `UART_RX_PARITY_EN` is defined.
- `cmd_one`, `cmd_two`, `cmd_three`, output, 1 each: one-cycle score pulses.
- `cmd_reset_score`, output, 1: one-cycle pulse.
- `team_sel`, output, 1: level; 0 = team 1, 1 = team 2.
- `run_en`, output, 1: level; the clock-run enable.
- `unknown_cmd`, output, 1: one-cycle strobe on an unrecognised byte.

## Operation
- **Input sync:** `rxd` passes through a 2-flop synchroniser whose flops reset to 1. All logic uses the synchronised value `rxs`.
- **Tick generator:** a counter 0..DIV-1 issues `tick` on wrap. It is cleared on entry to START, so sampling is phase-aligned to the falling edge. `tcnt` (4 bits) counts ticks within a bit.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_HIGH.
  - IDLE: when `rxs`=0, go to START and clear the tick counter and `tcnt`.
  - START: at `tcnt`=7 (mid start bit), if `rxs`=0 go to DATA with `tcnt` and `bitcnt` cleared; otherwise treat as a glitch and go to IDLE.
  - DATA: every 16 ticks sample `rxs` into a shift register, LSB first. After the 8th bit go to PARITY if the macro is defined, otherwise to STOP.
  - PARITY: sample after 16 ticks and compare with even parity of the 8 data bits.
  - STOP: sample after 16 ticks.
    - `rxs`=1 and parity OK: load `rx_data`, pulse `rx_valid`, go to IDLE.
    - `rxs`=1 and parity bad: pulse `parity_err`, leave `rx_data` unchanged, go to IDLE.
    - `rxs`=0: pulse `frame_err` (this takes precedence over a parity error), go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then go to IDLE. A held-low break therefore never re-triggers START.
- **Command decode:** acts on `rx_valid`, registered, so outputs appear one cycle later.
  - 0x31 '1' → `cmd_one`; 0x32 '2' → `cmd_two`; 0x33 '3' → `cmd_three`.
  - 0x41 'A' → `team_sel`=0; 0x42 'B' → `team_sel`=1.
  - 0x52 'R' → `cmd_reset_score`.
  - 0x50 'P' → toggles `run_en`.
  - Every other byte, including lowercase letters, CR and LF → `unknown_cmd`; no other output changes.
- **Reset values:** all outputs are 0, `rx_data`=0x00, the FSM is in IDLE and both synchroniser flops hold 1. An asserted `reset` aborts a frame in progress immediately, and the partial byte is discarded.

## Timing
- One bit period is 16·DIV clocks (5200 at defaults).
- Falling edge on `rxd` → START entry: 2–3 clocks (synchroniser).
- Stop-bit sample is at 9.5 bit periods after the falling edge (10.5 with parity), ±1 tick. `rx_valid` is asserted the clock after that sample.
- Command outputs are asserted exactly 1 clock after `rx_valid`, for exactly 1 clock. Level outputs change on that same edge.
- Back-to-back frames with zero idle time are supported. The new start edge is detected in IDLE directly after STOP; no byte is lost.
- A low glitch shorter than 8 ticks on the line is rejected.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined: the frame is 8E1; the PARITY state exists and `parity_err` is live.
- Undefined: the frame is 8N1; PARITY is omitted and `parity_err` is a constant 0.
- The command decode is identical in both builds.

## Test plan
- Send 0x31 at 9600 baud → `rx_data`=0x31, `rx_valid` high for 1 clock, `cmd_one` high for 1 clock on the next edge, no error strobes.
- Send 'B' then '2' back-to-back with no idle → `team_sel` goes 0→1, then `cmd_two` pulses; `rx_valid` pulses twice.
- Send 0x50 with stop bit = 0, line returns high, then send 0x50 correctly → first frame gives `frame_err` only with `run_en` staying 0; second frame sets `run_en`=1.
- Drive `rxd` low for 3·DIV clocks, then high → no START accepted, no strobes, FSM back in IDLE.
- Assert `reset` mid-frame at data bit 4, release it, then send 0x52 → all outputs 0 during reset; afterwards `cmd_reset_score` pulses once with `rx_data`=0x52.
- With `UART_RX_PARITY_EN` defined, send 0x33 with odd parity → `parity_err` pulses, no `rx_valid`, no `cmd_three`; with correct parity → `cmd_three` pulses.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// UART command receiver: 16x oversampled 8N1 (8E1 when UART_RX_PARITY_EN is defined)
// frame decoder that turns ASCII command bytes into score pulses and level controls.
module uart_cmd_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       cmd_one,
  output logic       cmd_two,
  output logic       cmd_three,
  output logic       cmd_reset_score,
  output logic       team_sel,
  output logic       run_en,
  output logic       unknown_cmd
);

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DCW-1:0] DIV_MAX = DCW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state, next_state;
  logic             rx_meta, rxs;
  logic [DCW-1:0]   div_cnt;
  logic [3:0]       tcnt;
  logic [2:0]       bitcnt;
  logic [7:0]       shift_reg;
  logic             tick, bit_end;
  logic             start_timer, clr_tcnt, shift_en, load_byte, set_ferr;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_en, set_perr;
`endif

  assign tick    = (div_cnt == DIV_MAX);
  assign bit_end = tick && (tcnt == 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      state   <= IDLE;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      state   <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    start_timer = 1'b0;
    clr_tcnt    = 1'b0;
    shift_en    = 1'b0;
    load_byte   = 1'b0;
    set_ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en      = 1'b0;
    set_perr    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxs) begin
          start_timer = 1'b1;
          next_state  = START;
        end
      end
      // Mid start bit: a line that is high again here was only a glitch.
      START: begin
        if (tick && (tcnt == 4'd7)) begin
          clr_tcnt   = 1'b1;
          next_state = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          par_en     = 1'b1;
          next_state = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          next_state = IDLE;
          if (!rxs) begin
            set_ferr   = 1'b1;
            next_state = WAIT_HIGH;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bit != ^shift_reg) set_perr = 1'b1;
`endif
          else load_byte = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rxs) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      tcnt      <= '0;
      bitcnt    <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (start_timer || tick) div_cnt <= '0;
      else                     div_cnt <= div_cnt + 1'b1;
      if (start_timer || clr_tcnt) tcnt <= '0;
      else if (tick)               tcnt <= tcnt + 1'b1;
      if (clr_tcnt)      bitcnt <= '0;
      else if (shift_en) bitcnt <= bitcnt + 1'b1;
      if (shift_en) shift_reg <= {rxs, shift_reg[7:1]};
      if (load_byte) rx_data <= shift_reg;
      rx_valid  <= load_byte;
      frame_err <= set_ferr;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) par_bit <= rxs;
      parity_err <= set_perr;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Command decode runs one cycle behind rx_valid, when rx_data already holds the byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_one         <= 1'b0;
      cmd_two         <= 1'b0;
      cmd_three       <= 1'b0;
      cmd_reset_score <= 1'b0;
      unknown_cmd     <= 1'b0;
      team_sel        <= 1'b0;
      run_en          <= 1'b0;
    end else begin
      cmd_one         <= 1'b0;
      cmd_two         <= 1'b0;
      cmd_three       <= 1'b0;
      cmd_reset_score <= 1'b0;
      unknown_cmd     <= 1'b0;
      if (rx_valid) begin
        case (rx_data)
          8'h31:   cmd_one         <= 1'b1;
          8'h32:   cmd_two         <= 1'b1;
          8'h33:   cmd_three       <= 1'b1;
          8'h41:   team_sel        <= 1'b0;
          8'h42:   team_sel        <= 1'b1;
          8'h52:   cmd_reset_score <= 1'b1;
          8'h50:   run_en          <= ~run_en;
          default: unknown_cmd     <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx; runs at 9600 baud with a small clock (DIV=4) so frames are short.
// Parity steps are included when UART_RX_PARITY_EN is defined.
module tb_uart_cmd_rx;

  localparam int CLK_FREQ = 614_400;
  localparam int BAUD     = 9600;
  localparam int DIV      = 4;
  localparam int BIT      = 16 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err;
  logic       cmd_one, cmd_two, cmd_three, cmd_reset_score;
  logic       team_sel, run_en, unknown_cmd;

  uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .parity_err(parity_err),
    .cmd_one(cmd_one), .cmd_two(cmd_two), .cmd_three(cmd_three),
    .cmd_reset_score(cmd_reset_score), .team_sel(team_sel), .run_en(run_en),
    .unknown_cmd(unknown_cmd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Strobe counters; each counts high cycles, so a pulse longer than one clock shows up as extra.
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_unk = 0;
  int n_one = 0, n_two = 0, n_three = 0, n_rst = 0;
  int valid_cyc = 0, cmd_lag = -1;
  always @(negedge clk) begin
    if (rx_valid)        begin n_valid++; valid_cyc = cyc; end
    if (frame_err)       n_ferr++;
    if (parity_err)      n_perr++;
    if (unknown_cmd)     n_unk++;
    if (cmd_one)         n_one++;
    if (cmd_two)         n_two++;
    if (cmd_three)       n_three++;
    if (cmd_reset_score) n_rst++;
    if (cmd_one || cmd_two || cmd_three || cmd_reset_score) cmd_lag = cyc - valid_cyc;
  end

  int b_valid, b_ferr, b_perr, b_unk, b_one, b_two, b_three, b_rst;
  int n_cmp = 0, n_fail = 0;

  task automatic snap();
    b_valid = n_valid; b_ferr = n_ferr; b_perr = n_perr; b_unk = n_unk;
    b_one = n_one; b_two = n_two; b_three = n_three; b_rst = n_rst;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    wait_clk(BIT);
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_bit);
    rxd = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_bad_parity(input logic [7:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(~(^b));
    drive_bit(1'b1);
  endtask
`endif

  initial begin
    $display("[TB] uart_cmd_rx directed test, bit period %0d clocks", BIT);
    wait_clk(4);
    check_output("reset_outputs",
      {14'd0, rx_data, rx_valid, frame_err, parity_err, cmd_one, cmd_two, cmd_three,
       cmd_reset_score, team_sel, run_en, unknown_cmd}, 32'd0);
    reset = 1'b0;
    wait_clk(BIT);

    // '1'
    snap();
    apply_stimulus(8'h31, 1'b1);
    wait_clk(8);
    check_output("one_data",  rx_data, 32'h31);
    check_output("one_valid", n_valid - b_valid, 1);
    check_output("one_pulse", n_one - b_one, 1);
    check_output("one_lag",   cmd_lag, 1);
    check_output("one_ferr",  n_ferr - b_ferr, 0);
    check_output("one_unk",   n_unk - b_unk, 0);

    // 'B' then '2' back-to-back
    snap();
    apply_stimulus(8'h42, 1'b1);
    apply_stimulus(8'h32, 1'b1);
    wait_clk(8);
    check_output("b2_team", team_sel, 1);
    check_output("b2_valid", n_valid - b_valid, 2);
    check_output("b2_two", n_two - b_two, 1);
    check_output("b2_data", rx_data, 32'h32);
    check_output("b2_unk", n_unk - b_unk, 0);

    // 'P' with a bad stop bit, then a held-low break
    snap();
    apply_stimulus(8'h50, 1'b0);
    rxd = 1'b0;
    wait_clk(2 * BIT);
    rxd = 1'b1;
    wait_clk(BIT);
    check_output("ferr_count", n_ferr - b_ferr, 1);
    check_output("ferr_valid", n_valid - b_valid, 0);
    check_output("ferr_run", run_en, 0);
    check_output("ferr_data", rx_data, 32'h32);

    snap();
    apply_stimulus(8'h50, 1'b1);
    wait_clk(8);
    check_output("p_run", run_en, 1);
    check_output("p_valid", n_valid - b_valid, 1);
    check_output("p_data", rx_data, 32'h50);
    check_output("p_ferr", n_ferr - b_ferr, 0);

    // Short low glitch, then a good '3'
    snap();
    rxd = 1'b0;
    wait_clk(3 * DIV);
    rxd = 1'b1;
    wait_clk(2 * BIT);
    check_output("glitch_valid", n_valid - b_valid, 0);
    check_output("glitch_ferr", n_ferr - b_ferr, 0);
    check_output("glitch_unk", n_unk - b_unk, 0);
    apply_stimulus(8'h33, 1'b1);
    wait_clk(8);
    check_output("three_pulse", n_three - b_three, 1);
    check_output("three_data", rx_data, 32'h33);

    // Reset in the middle of data bit 4 of an 'R'
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h52 >> i));
    rxd = 1'b0;
    wait_clk(BIT / 2);
    reset = 1'b1;
    rxd = 1'b1;
    #1;
    check_output("midreset_outputs",
      {14'd0, rx_data, rx_valid, frame_err, parity_err, cmd_one, cmd_two, cmd_three,
       cmd_reset_score, team_sel, run_en, unknown_cmd}, 32'd0);
    wait_clk(4);
    reset = 1'b0;
    wait_clk(BIT);
    snap();
    apply_stimulus(8'h52, 1'b1);
    wait_clk(8);
    check_output("r_pulse", n_rst - b_rst, 1);
    check_output("r_data", rx_data, 32'h52);
    check_output("r_lag", cmd_lag, 1);
    check_output("r_valid", n_valid - b_valid, 1);
    check_output("r_run", run_en, 0);

    // Unknown bytes: lowercase and CR leave levels untouched
    snap();
    apply_stimulus(8'h61, 1'b1);
    apply_stimulus(8'h0D, 1'b1);
    wait_clk(8);
    check_output("unk_count", n_unk - b_unk, 2);
    check_output("unk_data", rx_data, 32'h0D);
    check_output("unk_team", team_sel, 0);
    check_output("unk_run", run_en, 0);
    check_output("unk_cmds", (n_one - b_one) + (n_two - b_two) + (n_three - b_three) + (n_rst - b_rst), 0);

    // 'B', 'A', 'P', 'P'
    apply_stimulus(8'h42, 1'b1);
    wait_clk(8);
    check_output("team_b", team_sel, 1);
    apply_stimulus(8'h41, 1'b1);
    apply_stimulus(8'h50, 1'b1);
    wait_clk(8);
    check_output("team_a", team_sel, 0);
    check_output("run_toggle_on", run_en, 1);
    apply_stimulus(8'h50, 1'b1);
    wait_clk(8);
    check_output("run_toggle_off", run_en, 0);

`ifdef UART_RX_PARITY_EN
    snap();
    send_bad_parity(8'h33);
    wait_clk(8);
    check_output("par_err", n_perr - b_perr, 1);
    check_output("par_valid", n_valid - b_valid, 0);
    check_output("par_three", n_three - b_three, 0);
    check_output("par_data", rx_data, 32'h50);
    snap();
    apply_stimulus(8'h33, 1'b1);
    wait_clk(8);
    check_output("par_ok_three", n_three - b_three, 1);
    check_output("par_ok_err", n_perr - b_perr, 0);
`else
    check_output("no_parity_err", n_perr, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
